input_port_ctrl: RTL and testbench

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

---
 rtl/router_pkg.sv | 19 +
 rtl/grant_timer.sv | 28 ++
 rtl/input_port_ctrl.sv | 164 ++++++++++++++++
 tb/tb_input_port_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router input port.
// ROUTER_GRANT_TIMEOUT_EN enables grant timeout and frame drop.
package router_pkg;

   localparam int MAX_PORTS = 64;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      PAYLOAD,
      DROP
   } state_t;

   function automatic logic [MAX_PORTS-1:0] onehot(input logic [5:0] a);
      return {{(MAX_PORTS-1){1'b0}}, 1'b1} << a;
   endfunction

endpackage

// File: rtl/grant_timer.sv
// Counts WAIT cycles without a grant and flags the last allowed one.
module grant_timer #(
   parameter int LIMIT = 64
)(
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/input_port_ctrl.sv
// Router input port: serial address capture, request/grant, payload gate.
// ROUTER_GRANT_TIMEOUT_EN adds grant timeout, DROP state and drop_out.
module input_port_ctrl
   import router_pkg::*;
#(
   parameter int NUM_PORTS     = 16,
   parameter int ADDR_W        = $clog2(NUM_PORTS),
   parameter int GRANT_TIMEOUT = 64
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 din,
   input  logic                 frame_n,
   input  logic [NUM_PORTS-1:0] grant_in,
   output logic [NUM_PORTS-1:0] request_out,
   output logic                 data_enable_out,
   output logic [ADDR_W-1:0]    address_out,
   output logic                 drop_out,
   output logic                 runt_out
);

   if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS ||
       (NUM_PORTS & (NUM_PORTS - 1)) != 0) begin : g_bad_ports
      $error("NUM_PORTS must be a power of two in 2..64");
   end
   if (GRANT_TIMEOUT < 2 || GRANT_TIMEOUT > 1024) begin : g_bad_to
      $error("GRANT_TIMEOUT must be in 2..1024");
   end

   state_t                 r_state;
   logic [ADDR_W-1:0]      r_addr;
   logic [ADDR_W-1:0]      r_bit;
   logic [ADDR_W-1:0]      r_aout;
   logic [NUM_PORTS-1:0]   r_req;
   logic                   r_den;
   logic                   r_runt;
   logic [ADDR_W-1:0]      w_addr_fin;
   logic [NUM_PORTS-1:0]   w_req_fin;
   logic                   w_gnt;
   logic                   w_enter_wait;

   // Address as it will stand once the bit on din is captured.
   always_comb begin
      w_addr_fin = r_addr | ADDR_W'(din);
      if (r_state == IDLE) begin
         w_addr_fin = ADDR_W'(din) << (ADDR_W - 1);
      end
   end

   assign w_req_fin    = NUM_PORTS'(onehot(6'(w_addr_fin)));
   assign w_gnt        = |(grant_in & r_req);
   assign w_enter_wait = !frame_n &&
                         ((r_state == ADDR && r_bit == '0) ||
                          (ADDR_W == 1 && r_state == IDLE));

`ifdef ROUTER_GRANT_TIMEOUT_EN
   logic r_drop;
   logic w_expired;

   grant_timer #(
      .LIMIT (GRANT_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_enter_wait),
      .enable  (r_state == WAIT && !w_gnt),
      .expired (w_expired)
   );

   assign drop_out = r_drop;
`else
   assign drop_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_bit   <= '0;
         r_aout  <= '0;
         r_req   <= '0;
         r_den   <= 1'b0;
         r_runt  <= 1'b0;
`ifdef ROUTER_GRANT_TIMEOUT_EN
         r_drop  <= 1'b0;
`endif
      end else begin
         r_runt <= 1'b0;
`ifdef ROUTER_GRANT_TIMEOUT_EN
         r_drop <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (!frame_n) begin
                  r_addr <= w_addr_fin;
                  r_bit  <= ADDR_W'(ADDR_W - 2);
                  if (w_enter_wait) begin
                     r_state <= WAIT;
                     r_req   <= w_req_fin;
                     r_aout  <= w_addr_fin;
                  end else begin
                     r_state <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (frame_n) begin
                  r_state <= IDLE;
                  r_runt  <= 1'b1;
               end else begin
                  r_addr <= r_addr | (ADDR_W'(din) << r_bit);
                  r_bit  <= r_bit - 1'b1;
                  if (w_enter_wait) begin
                     r_state <= WAIT;
                     r_req   <= w_req_fin;
                     r_aout  <= w_addr_fin;
                  end
               end
            end
            WAIT: begin
               if (frame_n) begin
                  r_state <= IDLE;
                  r_req   <= '0;
               end else if (w_gnt) begin
                  r_state <= PAYLOAD;
                  r_den   <= 1'b1;
`ifdef ROUTER_GRANT_TIMEOUT_EN
               end else if (w_expired) begin
                  r_state <= DROP;
                  r_req   <= '0;
                  r_drop  <= 1'b1;
`endif
               end
            end
            PAYLOAD: begin
               if (frame_n) begin
                  r_state <= IDLE;
                  r_req   <= '0;
                  r_den   <= 1'b0;
               end
            end
            DROP: begin
               if (frame_n) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_addr  <= '0;
               r_bit   <= '0;
               r_aout  <= '0;
               r_req   <= '0;
               r_den   <= 1'b0;
            end
         endcase
      end
   end

   assign request_out     = r_req;
   assign data_enable_out = r_den;
   assign address_out     = r_aout;
   assign runt_out        = r_runt;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl (16 ports, 8-cycle grant timeout).
module tb_input_port_ctrl;

   localparam int NP = 16;
   localparam int AW = 4;
   localparam int GT = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          din;
   logic          frame_n;
   logic [NP-1:0] grant_in;
   logic [NP-1:0] request_out;
   logic          data_enable_out;
   logic [AW-1:0] address_out;
   logic          drop_out;
   logic          runt_out;

   int n_vec = 0;
   int n_err = 0;

   input_port_ctrl #(
      .NUM_PORTS     (NP),
      .GRANT_TIMEOUT (GT)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .din             (din),
      .frame_n         (frame_n),
      .grant_in        (grant_in),
      .request_out     (request_out),
      .data_enable_out (data_enable_out),
      .address_out     (address_out),
      .drop_out        (drop_out),
      .runt_out        (runt_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_addr(input logic [3:0] a);
      for (int i = 3; i >= 0; i--) begin
         chk("addr_req_quiet", 32'(request_out), 32'h0);
         frame_n = 1'b0;
         din     = a[i];
         step();
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      frame_n  = 1'b1;
      din      = 1'b0;
      grant_in = '0;
      #12;
      chk("rst_req",  32'(request_out), 32'h0);
      chk("rst_den",  32'(data_enable_out), 32'h0);
      chk("rst_aout", 32'(address_out), 32'h0);
      chk("rst_drop", 32'(drop_out), 32'h0);
      chk("rst_runt", 32'(runt_out), 32'h0);
      reset_n = 1'b1;
      step();
      step();

      // address A, grant in cycle 7
      send_addr(4'hA);
      chk("a_req",  32'(request_out), 32'h0400);
      chk("a_aout", 32'(address_out), 32'hA);
      chk("a_den0", 32'(data_enable_out), 32'h0);
      step();
      step();
      chk("a_req_hold", 32'(request_out), 32'h0400);
      step();
      grant_in = 16'h0400;
      chk("a_den_c7", 32'(data_enable_out), 32'h0);
      step();
      chk("a_den_c8", 32'(data_enable_out), 32'h1);
      chk("a_req_pl", 32'(request_out), 32'h0400);
      chk("a_aout_pl", 32'(address_out), 32'hA);
      grant_in = '0;
      frame_n  = 1'b1;
      step();
      chk("a_end_req", 32'(request_out), 32'h0);
      chk("a_end_den", 32'(data_enable_out), 32'h0);

      // back-to-back frame, foreign grants, end beats grant
      send_addr(4'h5);
      chk("b_req",  32'(request_out), 32'h0020);
      chk("b_aout", 32'(address_out), 32'h5);
      grant_in = 16'hFFDF;
      step();
      step();
      chk("b_foreign_den", 32'(data_enable_out), 32'h0);
      chk("b_foreign_req", 32'(request_out), 32'h0020);
      frame_n  = 1'b1;
      grant_in = 16'h0020;
      step();
      chk("b_end_req", 32'(request_out), 32'h0);
      chk("b_end_den", 32'(data_enable_out), 32'h0);
      grant_in = '0;
      step();

      // runt after two address bits
      frame_n = 1'b0;
      din     = 1'b1;
      step();
      step();
      chk("r_req_mid", 32'(request_out), 32'h0);
      frame_n = 1'b1;
      step();
      chk("r_pulse", 32'(runt_out), 32'h1);
      chk("r_req", 32'(request_out), 32'h0);
      step();
      chk("r_pulse_end", 32'(runt_out), 32'h0);
      chk("r_req_after", 32'(request_out), 32'h0);

      // grant lands on the 8th WAIT cycle
      send_addr(4'h7);
      repeat (7) step();
      chk("g_drop_c8", 32'(drop_out), 32'h0);
      chk("g_den_c8", 32'(data_enable_out), 32'h0);
      grant_in = 16'h0080;
      step();
      chk("g_den", 32'(data_enable_out), 32'h1);
      chk("g_drop", 32'(drop_out), 32'h0);
      chk("g_req", 32'(request_out), 32'h0080);
      grant_in = '0;
      frame_n  = 1'b1;
      step();
      chk("g_end_den", 32'(data_enable_out), 32'h0);

`ifdef ROUTER_GRANT_TIMEOUT_EN
      send_addr(4'h2);
      repeat (7) step();
      chk("t_drop_early", 32'(drop_out), 32'h0);
      chk("t_req_c8", 32'(request_out), 32'h0004);
      step();
      chk("t_drop", 32'(drop_out), 32'h1);
      chk("t_req", 32'(request_out), 32'h0);
      chk("t_den", 32'(data_enable_out), 32'h0);
      step();
      chk("t_drop_end", 32'(drop_out), 32'h0);
      chk("t_req_drop", 32'(request_out), 32'h0);
      frame_n = 1'b1;
      step();
      send_addr(4'h1);
      chk("t_next_req", 32'(request_out), 32'h0002);
      chk("t_next_aout", 32'(address_out), 32'h1);
      frame_n = 1'b1;
      step();
`else
      begin
         int seen = 0;
         send_addr(4'h0);
         repeat (2000) begin
            step();
            if (drop_out !== 1'b0) seen++;
         end
         chk("h_drop_seen", 32'(seen), 32'h0);
         chk("h_req", 32'(request_out), 32'h0001);
         chk("h_aout", 32'(address_out), 32'h0);
         frame_n = 1'b1;
         step();
      end
`endif

      // reset in the middle of PAYLOAD
      send_addr(4'hC);
      grant_in = 16'h1000;
      step();
      chk("x_den", 32'(data_enable_out), 32'h1);
      #2;
      reset_n  = 1'b0;
      frame_n  = 1'b1;
      grant_in = '0;
      #1;
      chk("x_rst_den",  32'(data_enable_out), 32'h0);
      chk("x_rst_req",  32'(request_out), 32'h0);
      chk("x_rst_aout", 32'(address_out), 32'h0);
      chk("x_rst_drop", 32'(drop_out), 32'h0);
      chk("x_rst_runt", 32'(runt_out), 32'h0);
      #2;
      reset_n = 1'b1;
      step();
      chk("x_idle_req", 32'(request_out), 32'h0);
      send_addr(4'h3);
      chk("x_req", 32'(request_out), 32'h0008);
      chk("x_aout", 32'(address_out), 32'h3);
      frame_n = 1'b1;
      step();
      chk("x_end_req", 32'(request_out), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
